// File: rtl/ndp_axis_tx.sv
// ndp_axis_tx: serialises full-width result vectors from the systolic-array
// output stage onto a 32-bit AXI4-Stream master. Each frame is
// ROWS_PER_FRAME vectors, and tlast marks the frame's final beat.
module ndp_axis_tx #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned AXIS_WIDTH     = 32,
  parameter int unsigned LANES          = 16,
  parameter int unsigned ROWS_PER_FRAME = 4
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [LANES*WIDTH-1:0]   res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic [AXIS_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int unsigned DW    = LANES * WIDTH;
  localparam int unsigned BEATS = DW / AXIS_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  logic [DW-1:0]         slot_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  done_q, done_d;
  // Keeps res_ready low while in reset; set on the first edge after release.
  logic                  en_q;

  logic                  accept;
  logic                  hs;
  logic                  last_beat;
  logic                  last_row;
  logic                  free;
  logic [AXIS_WIDTH-1:0] beats [BEATS];

  assign res_ready     = en_q && (count_q != 2'd2);
  assign m_axis_tvalid = (count_q != 2'd0);
  assign last_beat     = (beat_q == BW'(BEATS - 1));
  assign last_row      = (row_q == RW'(ROWS_PER_FRAME - 1));
  assign accept        = res_valid && res_ready;
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign free          = hs && last_beat;
  assign m_axis_tlast  = m_axis_tvalid && last_beat && last_row;
  assign busy          = m_axis_tvalid || (row_q != '0);
  assign frame_done    = done_q;

  // Split the head slot into AXIS-wide beats; lowest lanes go out first.
  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      beats[b] = slot_q[rd_ptr_q][b*AXIS_WIDTH +: AXIS_WIDTH];
    end
  end

  // Beat mux, forced to zero when nothing is valid.
  assign m_axis_tdata = m_axis_tvalid ? beats[beat_q] : '0;

  // Next-state for pointers, occupancy, beat/row counters and done pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;
    row_d    = row_q;
    done_d   = free && last_row;

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (hs) begin
      beat_d = beat_q + BW'(1);
      if (last_beat) begin
        beat_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
        row_d    = last_row ? '0 : row_q + RW'(1);
      end
    end

    // Accept and free in the same cycle leave the occupancy unchanged.
    case ({accept, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset discards any partial frame.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      beat_q   <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      row_q    <= row_d;
      done_q   <= done_d;
      en_q     <= 1'b1;
    end
  end

  // Vector storage; contents are only observed while the slot is occupied.
  always_ff @(posedge axi_aclk) begin
    if (accept) begin
      slot_q[wr_ptr_q] <= res_data;
    end
  end

endmodule

// File: tb/tb_ndp_axis_tx.sv
// Directed testbench for ndp_axis_tx: a vector table for the single-vector
// case plus hand-written sequences with a beat scoreboard.
module tb_ndp_axis_tx;

  localparam int W  = 16;
  localparam int AW = 32;
  localparam int L  = 16;
  localparam int DW = L * W;
  localparam int NB = 8;
  localparam int FB = 32;

  typedef logic [DW-1:0] vec_t;

  typedef struct {
    logic        rv;
    logic        trdy;
    logic        e_tvalid;
    logic        e_rready;
    logic        e_tlast;
    logic        e_busy;
    logic [31:0] e_tdata;
  } vrow_t;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn;
  vec_t          res_data;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          frame_done;
  logic          busy;

  always #5 axi_aclk = ~axi_aclk;

  ndp_axis_tx dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  int            checks   = 0;
  int            failures = 0;
  vec_t          pending [$];
  logic [AW-1:0] exp_q [$];
  int            acc_at [$];
  int            beat_idx;
  int            done_cnt;
  int            cyc_n;
  int            first_hs;
  int            last_hs;
  vrow_t         tbl [10];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk_vec(int base);
    vec_t v;
    for (int i = 0; i < L; i++) v[i*W +: W] = 16'(base + i);
    return v;
  endfunction

  // Beat b is {lane 2b+1, lane 2b}.
  function automatic logic [AW-1:0] exp_beat(vec_t v, int b);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    lo = v[(2*b)*W +: W];
    hi = v[(2*b+1)*W +: W];
    return {hi, lo};
  endfunction

  task automatic clear_sb();
    pending.delete();
    exp_q.delete();
    acc_at.delete();
    beat_idx = 0;
    done_cnt = 0;
    cyc_n    = 0;
    first_hs = -1;
    last_hs  = -1;
  endtask

  // One clock: score this cycle's handshakes, advance, check frame_done.
  task automatic cyc();
    logic nd;
    nd = 1'b0;
    if (res_valid && res_ready) begin
      for (int b = 0; b < NB; b++) exp_q.push_back(exp_beat(res_data, b));
      acc_at.push_back(beat_idx);
      if (pending.size() > 0) void'(pending.pop_front());
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
      else check($sformatf("tdata_beat%0d", beat_idx), 64'(m_axis_tdata), 64'(exp_q.pop_front()));
      nd = ((beat_idx % FB) == FB - 1);
      check($sformatf("tlast_beat%0d", beat_idx), 64'(m_axis_tlast), 64'(nd));
      if (first_hs < 0) first_hs = cyc_n;
      last_hs = cyc_n;
      beat_idx++;
    end
    @(posedge axi_aclk);
    #1;
    cyc_n++;
    check("frame_done", 64'(frame_done), 64'(nd));
    if (frame_done) done_cnt++;
  endtask

  task automatic drive();
    if (pending.size() > 0) begin
      res_valid = 1'b1;
      res_data  = pending[0];
    end else begin
      res_valid = 1'b0;
    end
  endtask

  // mode 0: tready held high; mode 1: tready random 50%.
  task automatic run_drain(int mode, int budget);
    int n;
    n = 0;
    while ((pending.size() > 0 || exp_q.size() > 0) && n < budget) begin
      drive();
      m_axis_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    res_valid = 1'b0;
    check("drain_left", 64'(exp_q.size() + pending.size()), 64'd0);
  endtask

  task automatic do_reset();
    axi_aresetn   = 1'b0;
    res_valid     = 1'b0;
    res_data      = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1;
    clear_sb();
    check("rst_res_ready", 64'(res_ready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    check("ready_after_rst", 64'(res_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic          stable_ok;
    logic          have_ref;
    logic [AW-1:0] ref_data;
    vec_t          va;
    vec_t          vb;
    int            n;

    // Single-vector table: row 0 is the accept cycle, rows 1-8 show beats 0-7.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int r = 1; r <= NB; r++) begin
      tbl[r] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                 {16'(16'h3C01 + 2*(r-1)), 16'(16'h3C00 + 2*(r-1))}};
    end
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};

    // Test 1: single vector through the table.
    do_reset();
    res_data = mk_vec(16'h3C00);
    for (int r = 0; r < 10; r++) begin
      res_valid     = tbl[r].rv;
      m_axis_tready = tbl[r].trdy;
      check($sformatf("t1_r%0d_tvalid", r), 64'(m_axis_tvalid), 64'(tbl[r].e_tvalid));
      check($sformatf("t1_r%0d_rready", r), 64'(res_ready), 64'(tbl[r].e_rready));
      check($sformatf("t1_r%0d_tlast", r), 64'(m_axis_tlast), 64'(tbl[r].e_tlast));
      check($sformatf("t1_r%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
      check($sformatf("t1_r%0d_tdata", r), 64'(m_axis_tdata), 64'(tbl[r].e_tdata));
      @(posedge axi_aclk);
      #1;
    end

    // Test 2: full frame, back-to-back, no bubbles.
    do_reset();
    for (int v = 0; v < 4; v++) pending.push_back(mk_vec(16'h2000 + v*16));
    run_drain(0, 200);
    check("t2_beats", 64'(beat_idx), 64'd32);
    check("t2_span", 64'(last_hs - first_hs), 64'd31);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    m_axis_tready = 1'b1;
    cyc();
    check("t2_done_cnt_after", 64'(done_cnt), 64'd1);

    // Test 3: backpressure with three vectors offered.
    do_reset();
    for (int v = 0; v < 3; v++) pending.push_back(mk_vec(16'h3000 + v*16));
    m_axis_tready = 1'b0;
    stable_ok = 1'b1;
    have_ref  = 1'b0;
    ref_data  = '0;
    for (int c = 0; c < 20; c++) begin
      drive();
      cyc();
      if (have_ref) begin
        if (!m_axis_tvalid || m_axis_tdata !== ref_data || m_axis_tlast !== 1'b0) stable_ok = 1'b0;
      end else if (m_axis_tvalid) begin
        have_ref = 1'b1;
        ref_data = m_axis_tdata;
      end
    end
    check("t3_stall_stable", 64'(stable_ok), 64'd1);
    check("t3_stall_ref", 64'(ref_data), 64'(exp_beat(mk_vec(16'h3000), 0)));
    check("t3_accepts_in_stall", 64'(acc_at.size()), 64'd2);
    check("t3_res_ready_full", 64'(res_ready), 64'd0);
    run_drain(0, 200);
    check("t3_accepts_total", 64'(acc_at.size()), 64'd3);
    if (acc_at.size() == 3) check("t3_third_accept_beat", 64'(acc_at[2]), 64'd8);
    check("t3_busy_partial", 64'(busy), 64'd1);

    // Test 4: random tready across three frames.
    do_reset();
    for (int v = 0; v < 12; v++) pending.push_back(mk_vec(16'h4000 + v*16));
    run_drain(1, 3000);
    check("t4_beats", 64'(beat_idx), 64'd96);
    check("t4_done_cnt", 64'(done_cnt), 64'd3);

    // Test 5: accept on the same edge as the final-beat free.
    do_reset();
    va = mk_vec(16'h5000);
    vb = mk_vec(16'h6000);
    res_valid     = 1'b1;
    res_data      = va;
    m_axis_tready = 1'b1;
    cyc();
    res_valid = 1'b0;
    repeat (7) cyc();
    check("t5_last_beat_data", 64'(m_axis_tdata), 64'(exp_beat(va, 7)));
    check("t5_ready_before", 64'(res_ready), 64'd1);
    res_valid = 1'b1;
    res_data  = vb;
    cyc();
    res_valid = 1'b0;
    check("t5_accepted", 64'(acc_at.size()), 64'd2);
    check("t5_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t5_new_beat0", 64'(m_axis_tdata), 64'(exp_beat(vb, 0)));
    check("t5_ready_after", 64'(res_ready), 64'd1);
    run_drain(0, 50);
    check("t5_beats", 64'(beat_idx), 64'd16);

    // Test 6: reset mid-frame, then a clean frame.
    do_reset();
    for (int v = 0; v < 2; v++) pending.push_back(mk_vec(16'h7000 + v*16));
    n = 0;
    while (beat_idx < 5 && n < 50) begin
      drive();
      m_axis_tready = 1'b1;
      cyc();
      n++;
    end
    check("t6_pre_accepts", 64'(acc_at.size()), 64'd2);
    check("t6_pre_beats", 64'(beat_idx), 64'd5);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_ready", 64'(res_ready), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_tlast", 64'(m_axis_tlast), 64'd0);
    do_reset();
    for (int v = 0; v < 4; v++) pending.push_back(mk_vec(16'h7800 + v*16));
    run_drain(0, 200);
    check("t6_beats", 64'(beat_idx), 64'd32);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
